// File: rtl/turn_sequencer_if.sv
// turn_sequencer_if: front-end, checker and status signals around the turn sequencer
interface turn_sequencer_if #(parameter int POS_W = 5);
    logic             start;
    logic             flip_valid;
    logic             match;
    logic [POS_W-1:0] step_n;
    logic             W;
    logic [POS_W-1:0] pos_data;
    logic [1:0]       T;
    logic [POS_W-1:0] N;
    logic             B;
    logic [POS_W-1:0] last_pos;
    logic             game_over;
    logic [1:0]       winner;
    logic             busy;

    modport master (
        input  start, flip_valid, match, step_n, W, pos_data,
        output T, N, B, last_pos, game_over, winner, busy
    );

    modport slave (
        output start, flip_valid, match, step_n, W, pos_data,
        input  T, N, B, last_pos, game_over, winner, busy
    );
endinterface

// File: rtl/turn_sequencer.sv
// turn_sequencer: rotates turns, issues move strobes to the win checker and latches its result
module turn_sequencer #(
    parameter int NUM_PLAYERS    = 4,
    parameter int POS_W          = 5,
    parameter int RESULT_LAT     = 1,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input logic               clk,
    input logic               rst,
    turn_sequencer_if.master  bus
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 8);

    typedef enum logic [2:0] {IDLE, WAIT_FLIP, ISSUE, WAIT_RESULT, NEXT, DONE} state_t;

    state_t           state, state_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [1:0]       t_d, winner_d;
    logic [POS_W-1:0] n_d, last_pos_d;
    logic             b_d, game_over_d, busy_d;

    // cnt is the idle timer in WAIT_FLIP and the result-latency timer from the B cycle onward
    always_comb begin
        state_d     = state;
        cnt_d       = '0;
        t_d         = bus.T;
        n_d         = bus.N;
        last_pos_d  = bus.last_pos;
        winner_d    = bus.winner;
        game_over_d = bus.game_over;
        case (state)
            IDLE: if (bus.start) begin
                state_d = WAIT_FLIP;
                t_d     = '0;
            end
            WAIT_FLIP: begin
                if (bus.flip_valid) begin
                    state_d = (bus.match && bus.step_n != '0) ? ISSUE : NEXT;
                    n_d     = (bus.match && bus.step_n != '0) ? bus.step_n : bus.N;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1))
                    state_d = NEXT;
                else
                    cnt_d = cnt + 1'b1;
            end
            ISSUE: begin
                state_d = WAIT_RESULT;
                cnt_d   = cnt + 1'b1;
            end
            WAIT_RESULT: begin
                if (cnt == CW'(RESULT_LAT)) begin
                    last_pos_d  = bus.pos_data;
                    state_d     = bus.W ? DONE : WAIT_FLIP;
                    winner_d    = bus.W ? bus.T : bus.winner;
                    game_over_d = bus.W;
                end else
                    cnt_d = cnt + 1'b1;
            end
            NEXT: begin
                t_d     = (bus.T == 2'(NUM_PLAYERS - 1)) ? 2'd0 : bus.T + 2'd1;
                state_d = WAIT_FLIP;
            end
            DONE: ;
            default: state_d = IDLE;
        endcase
        b_d    = (state_d == ISSUE);
        busy_d = (state_d != IDLE) && (state_d != DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.T         <= '0;
            bus.N         <= '0;
            bus.B         <= 1'b0;
            bus.last_pos  <= '0;
            bus.game_over <= 1'b0;
            bus.winner    <= '0;
            bus.busy      <= 1'b0;
        end else begin
            state         <= state_d;
            cnt           <= cnt_d;
            bus.T         <= t_d;
            bus.N         <= n_d;
            bus.B         <= b_d;
            bus.last_pos  <= last_pos_d;
            bus.game_over <= game_over_d;
            bus.winner    <= winner_d;
            bus.busy      <= busy_d;
        end
    end
endmodule

// File: tb/tb_turn_sequencer.sv
// tb_turn_sequencer: directed self-checking bench for turn_sequencer
module tb_turn_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int compared = 0;
    int mismatched = 0;

    turn_sequencer_if #(.POS_W(5)) bus();

    turn_sequencer #(
        .NUM_PLAYERS(4), .POS_W(5), .RESULT_LAT(1), .TIMEOUT_CYCLES(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flip(input logic m, input logic [4:0] s);
        bus.flip_valid = 1'b1;
        bus.match      = m;
        bus.step_n     = s;
        tick();
        bus.flip_valid = 1'b0;
        bus.match      = 1'b0;
        bus.step_n     = '0;
    endtask

    task automatic start_game();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    initial begin
        bus.start = 0; bus.flip_valid = 0; bus.match = 0; bus.step_n = '0;
        bus.W = 0; bus.pos_data = '0;
        #1;
        chk("rst_T", bus.T, 0);
        chk("rst_B", bus.B, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_game_over", bus.game_over, 0);
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("idle_busy", bus.busy, 0);

        start_game();
        chk("start_busy", bus.busy, 1);
        chk("start_T", bus.T, 0);

        bus.pos_data = 5'd3;
        flip(1'b1, 5'd3);
        chk("move_B", bus.B, 1);
        chk("move_N", bus.N, 3);
        chk("move_T", bus.T, 0);
        tick();
        chk("move_B_single", bus.B, 0);
        tick();
        chk("move_last_pos", bus.last_pos, 3);
        chk("move_keep_T", bus.T, 0);
        chk("move_B_after", bus.B, 0);

        flip(1'b0, 5'd2);
        chk("miss_T_hold", bus.T, 0);
        chk("miss_no_B", bus.B, 0);
        tick();
        chk("miss_T1", bus.T, 1);
        for (int i = 0; i < 3; i++) begin
            flip(1'b0, 5'd1);
            chk("miss_no_B_loop", bus.B, 0);
            tick();
            chk("miss_rotate", bus.T, (i + 2) % 4);
        end

        flip(1'b1, 5'd0);
        chk("zero_step_no_B", bus.B, 0);
        tick();
        chk("zero_step_T", bus.T, 1);
        chk("zero_step_N_hold", bus.N, 3);

        for (int i = 0; i < 10; i++) tick();
        chk("timeout_T_pending", bus.T, 1);
        tick();
        chk("timeout_T", bus.T, 2);

        for (int i = 0; i < 9; i++) tick();
        chk("pre_timeout_T", bus.T, 2);
        bus.W = 1'b1;
        bus.pos_data = 5'd24;
        flip(1'b1, 5'd5);
        chk("race_B", bus.B, 1);
        chk("race_N", bus.N, 5);
        chk("race_T", bus.T, 2);
        tick();
        chk("win_pending", bus.game_over, 0);
        tick();
        chk("win_game_over", bus.game_over, 1);
        chk("win_winner", bus.winner, 2);
        chk("win_last_pos", bus.last_pos, 24);
        chk("win_busy", bus.busy, 0);
        bus.W = 1'b0;
        bus.pos_data = 5'd7;

        start_game();
        flip(1'b1, 5'd7);
        for (int i = 0; i < 12; i++) tick();
        chk("done_B", bus.B, 0);
        chk("done_game_over", bus.game_over, 1);
        chk("done_winner", bus.winner, 2);
        chk("done_last_pos", bus.last_pos, 24);
        chk("done_busy", bus.busy, 0);

        rst = 1'b0;
        #1;
        chk("done_rst_game_over", bus.game_over, 0);
        chk("done_rst_winner", bus.winner, 0);
        chk("done_rst_last_pos", bus.last_pos, 0);
        rst = 1'b1;
        tick();

        bus.pos_data = 5'd4;
        start_game();
        flip(1'b0, 5'd0);
        tick();
        chk("abort_setup_T", bus.T, 1);
        flip(1'b1, 5'd4);
        chk("abort_B", bus.B, 1);
        chk("abort_N", bus.N, 4);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_T", bus.T, 0);
        chk("abort_N_rst", bus.N, 0);
        chk("abort_busy", bus.busy, 0);
        chk("abort_last_pos", bus.last_pos, 0);
        #2;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flip(1'b1, 5'd2);
            chk("idle_no_B", bus.B, 0);
        end
        chk("idle_busy_after", bus.busy, 0);
        start_game();
        flip(1'b1, 5'd2);
        chk("restart_B", bus.B, 1);
        chk("restart_N", bus.N, 2);
        chk("restart_T", bus.T, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/turn_sequencer.md
Name: turn_sequencer

Overview:
- Game-flow controller that drives the win checker's turn/step/move interface.
- Consumes card-flip results from the input front end and decides whose turn it is and how far they move.
- Issues single-cycle move strobes with turn and step values, then samples the checker's win flag and post-move position.
- Sits between the button/card logic and the win checker; owns rotation of turns among players.

Parameters:
NUM_PLAYERS, 4, active players (2..4); turn index wraps at NUM_PLAYERS-1
POS_W, 5, width of step count and position data
RESULT_LAT, 1, cycles from move strobe to valid checker result (1..7)
TIMEOUT_CYCLES, 50000000, idle cycles in a turn before it passes automatically (>=2)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; begins a game from IDLE
flip_valid  input  1  one-cycle pulse; current player has flipped a card
match  input  1  qualifies flip_valid; 1 = card matches the target tile
step_n  input  POS_W  tiles to advance on a match; qualifies flip_valid
W  input  1  win flag from checker
pos_data  input  POS_W  post-move position from checker
T  output  2  current player index
N  output  POS_W  step count for the current move; valid while B=1
B  output  1  move strobe, exactly one cycle per move
last_pos  output  POS_W  registered pos_data from the most recent move
game_over  output  1  high once a winner is found
winner  output  2  winning player index; valid while game_over=1
busy  output  1  high in every state except IDLE and DONE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. T=0, N=0, B=0, last_pos=0, game_over=0, winner=0, busy=0, timeout counter=0.
- All outputs are registered.
- States: IDLE, WAIT_FLIP, ISSUE, WAIT_RESULT, NEXT, DONE.
- IDLE: start=1 -> WAIT_FLIP with T=0. Other inputs are ignored.
- WAIT_FLIP: timeout counter increments each cycle; it clears on entry.
  - flip_valid=1 & match=1 & step_n!=0 -> ISSUE; latch N=step_n.
  - flip_valid=1 & (match=0 | step_n==0) -> NEXT.
  - Counter reaches TIMEOUT_CYCLES-1 with no flip -> NEXT.
  - If flip_valid arrives on the same cycle as the timeout, flip_valid wins.
- ISSUE: B=1 for this single cycle; N holds the latched value and T is stable. Next state is WAIT_RESULT. B is 0 in all other states.
- WAIT_RESULT: wait RESULT_LAT cycles counted from the B cycle, then sample W and pos_data. last_pos updates on the sample cycle.
  - W=1 -> DONE; winner=T, game_over=1.
  - W=0 -> WAIT_FLIP with the same player, who keeps the turn after a successful match.
- NEXT: one cycle. T = (T==NUM_PLAYERS-1) ? 0 : T+1. Next state is WAIT_FLIP.
- DONE: game_over=1; winner and last_pos are held; busy=0. start, flip_valid and timeout are ignored. Only rst leaves DONE, because the checker's counters also restart only on rst.
- flip_valid in ISSUE, WAIT_RESULT or NEXT is dropped, not queued.
- start outside IDLE is ignored.
- N keeps its last value when B=0; consumers qualify N with B.
- Reset mid-move (ISSUE or WAIT_RESULT) aborts with no further B pulse. Outputs return to reset values immediately (asynchronous reset).
- T never exceeds NUM_PLAYERS-1, e.g. with NUM_PLAYERS=3 the sequence is 0,1,2,0.

Test Plan:
- Reset, start, flip_valid/match=1/step_n=3 -> B high one cycle with T=0, N=3. With W=0 and pos_data=3 after RESULT_LAT: last_pos=3, T stays 0, back to WAIT_FLIP.
- Player 0 miss (match=0) -> T=1 two cycles later, no B pulse. Three further misses (NUM_PLAYERS=4) -> T sequence 2,3,0.
- Match with step_n=0 -> no B pulse; T advances as for a miss.
- No flip for TIMEOUT_CYCLES (set to 10 in bench) -> T advances exactly on cycle 10. flip_valid on that same cycle -> flip processed, no timeout.
- Player 2 match with step_n=5 and checker returning W=1, pos_data=24 -> game_over=1, winner=2, last_pos=24, busy=0. Later start and flip_valid pulses cause no change.
- rst asserted the cycle after B -> all outputs 0 asynchronously, state IDLE; no B pulse after release until start plus a matching flip.
